// File: rtl/execid_arbiter_if.sv
// Request/grant bundle for execid_arbiter: requesters drive REQ/ID/REL,
// the arbiter drives the registered grant and status outputs.
interface execid_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]       REQ;
    logic [N*WIDTH-1:0] ID;
    logic [N-1:0]       REL;
    logic [N-1:0]       GNT;
    logic [IW-1:0]      GNT_IDX;
    logic               BUSY;
    logic               ERR;

    modport master (output REQ, ID, REL, input GNT, GNT_IDX, BUSY, ERR);
    modport slave  (input REQ, ID, REL, output GNT, GNT_IDX, BUSY, ERR);
endinterface

// File: rtl/execid_arbiter.sv
// Oldest-execution-ID arbiter for one mutually-exclusive resource: registered
// one-hot grant, explicit release, optional hold-time watchdog, sticky ERR.
module execid_arbiter #(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 0
) (
    input  logic              CLK,
    input  logic              RST,
    execid_arbiter_if.slave   bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int P  = 1 << IW;
    localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] CMAX = CW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

    typedef enum logic {IDLE, HELD} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;

    logic            holder_rel, timeout, arb, bad_rel;
    logic [N-1:0]    excl, cand;

    logic            win_v;
    logic [IW-1:0]   win_idx;

    // a is older than b when (a - b) mod 2^WIDTH has its top bit set
    function automatic logic older(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] d;
        d = a - b;
        return d[WIDTH-1];
    endfunction

    assign holder_rel = (state_q == HELD) && |(bus.REL & gnt_q);
    // counter reads HOLD_MAX-1 during the last permitted cycle of a hold
    assign timeout    = (HOLD_MAX > 0) && (state_q == HELD) && (cnt_q == CMAX);
    assign arb        = (state_q == IDLE) || holder_rel || timeout;
    assign excl       = (holder_rel || timeout) ? gnt_q : '0;
    assign cand       = bus.REQ & ~excl;
    assign bad_rel    = (state_q == IDLE) ? |bus.REL : |(bus.REL & ~gnt_q);

    // Binary tournament over a power-of-two padded leaf set; left child holds
    // lower indices, so ties fall to the lowest index.
    logic [2*P-2:0]   t_v;
    logic [IW-1:0]    t_idx [2*P-1];
    logic [WIDTH-1:0] t_id  [2*P-1];
    logic [P-1:0]     cand_pad;
    logic [P*WIDTH-1:0] id_pad;

    always_comb begin
        cand_pad = '0;
        cand_pad[N-1:0] = cand;
        id_pad = '0;
        id_pad[N*WIDTH-1:0] = bus.ID;
        t_v = '0;
        for (int k = 0; k < 2*P-1; k++) begin
            t_idx[k] = '0;
            t_id[k]  = '0;
        end
        for (int i = 0; i < P; i++) begin
            t_v[P-1+i]   = cand_pad[i];
            t_idx[P-1+i] = IW'(i);
            t_id[P-1+i]  = id_pad[i*WIDTH +: WIDTH];
        end
        for (int n = P-2; n >= 0; n--) begin
            if (t_v[2*n+2] && (!t_v[2*n+1] || older(t_id[2*n+2], t_id[2*n+1]))) begin
                t_v[n]   = 1'b1;
                t_idx[n] = t_idx[2*n+2];
                t_id[n]  = t_id[2*n+2];
            end else begin
                t_v[n]   = t_v[2*n+1];
                t_idx[n] = t_idx[2*n+1];
                t_id[n]  = t_id[2*n+1];
            end
        end
        win_v   = t_v[0];
        win_idx = t_idx[0];
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        cnt_d   = (state_q == HELD) ? cnt_q + 1'b1 : cnt_q;
        // a release in the timeout cycle wins over the timeout
        err_d   = err_q | bad_rel | (timeout & ~holder_rel);
        if (arb) begin
            if (win_v) begin
                state_d = HELD;
                gnt_d   = '0;
                gnt_d[win_idx] = 1'b1;
                idx_d   = win_idx;
                cnt_d   = '0;
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.GNT     = gnt_q;
    assign bus.GNT_IDX = idx_q;
    assign bus.BUSY    = (state_q == HELD);
    assign bus.ERR     = err_q;
endmodule

// File: tb/tb_execid_arbiter.sv
// Directed checks of execid_arbiter: age order, wrap, hold, bad release,
// watchdog timeout/handover and reset mid-grant.
module tb_execid_arbiter;
    logic CLK = 1'b0;
    logic RST;
    int   ncmp = 0;
    int   nfail = 0;

    always #5 CLK = ~CLK;

    execid_arbiter_if #(.N(4), .WIDTH(8)) i0 ();
    execid_arbiter_if #(.N(4), .WIDTH(8)) i1 ();

    execid_arbiter #(.N(4), .WIDTH(8), .HOLD_MAX(0)) dut0 (.CLK(CLK), .RST(RST), .bus(i0.slave));
    execid_arbiter #(.N(4), .WIDTH(8), .HOLD_MAX(3)) dut1 (.CLK(CLK), .RST(RST), .bus(i1.slave));

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic [3:0] g, input logic [1:0] ix,
                        input logic b, input logic e);
        chk({tag, ".gnt"}, 32'(i0.GNT), 32'(g));
        chk({tag, ".idx"}, 32'(i0.GNT_IDX), 32'(ix));
        chk({tag, ".busy"}, 32'(i0.BUSY), 32'(b));
        chk({tag, ".err"}, 32'(i0.ERR), 32'(e));
    endtask

    task automatic chk1(input string tag, input logic [3:0] g, input logic [1:0] ix,
                        input logic b, input logic e);
        chk({tag, ".gnt1"}, 32'(i1.GNT), 32'(g));
        chk({tag, ".idx1"}, 32'(i1.GNT_IDX), 32'(ix));
        chk({tag, ".busy1"}, 32'(i1.BUSY), 32'(b));
        chk({tag, ".err1"}, 32'(i1.ERR), 32'(e));
    endtask

    initial begin
        RST = 1'b1;
        i0.REQ = '0; i0.ID = '0; i0.REL = '0;
        i1.REQ = '0; i1.ID = '0; i1.REL = '0;
        step(); step();
        chk0("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk1("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        RST = 1'b0;

        // age order: IDs {10,7,9,7}, tie on 7 goes to index 1
        i0.REQ = 4'b1111;
        i0.ID  = {8'd7, 8'd9, 8'd7, 8'd10};
        step();
        chk0("age", 4'b0010, 2'd1, 1'b1, 1'b0);
        i0.REL = 4'b0010;
        step();
        i0.REL = '0;
        chk0("handover", 4'b1000, 2'd3, 1'b1, 1'b0);
        i0.REL = 4'b1000;
        step();
        i0.REL = '0;
        chk0("handover2", 4'b0010, 2'd1, 1'b1, 1'b0);
        i0.REQ = '0;
        i0.REL = 4'b0010;
        step();
        i0.REL = '0;
        chk0("to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // wrap-around: 0xFE is older than 0x02
        i0.REQ = 4'b0011;
        i0.ID  = {8'd0, 8'd0, 8'hFE, 8'h02};
        step();
        chk0("wrap", 4'b0010, 2'd1, 1'b1, 1'b0);
        i0.REQ = '0; i0.REL = 4'b0010;
        step();
        i0.REL = '0;
        chk0("wrap_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
        i0.REQ = 4'b0011;
        i0.ID  = {8'd0, 8'd0, 8'h02, 8'hFE};
        step();
        chk0("wrap_swap", 4'b0001, 2'd0, 1'b1, 1'b0);
        i0.REQ = '0; i0.REL = 4'b0001;
        step();
        i0.REL = '0;
        chk0("wrap_swap_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

        // holder keeps the grant after dropping REQ
        i0.REQ = 4'b0100;
        step();
        chk0("hold_gnt", 4'b0100, 2'd2, 1'b1, 1'b0);
        i0.REQ = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_noreq.gnt", 32'(i0.GNT), 32'h4);
            chk("hold_noreq.busy", 32'(i0.BUSY), 32'h1);
        end
        i0.REL = 4'b0100;
        step();
        i0.REL = '0;
        chk0("hold_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

        // release by a non-holder
        i0.REQ = 4'b0001;
        step();
        chk0("bad_pre", 4'b0001, 2'd0, 1'b1, 1'b0);
        i0.REQ = '0; i0.REL = 4'b1000;
        step();
        i0.REL = '0;
        chk0("bad_rel", 4'b0001, 2'd0, 1'b1, 1'b1);
        step(); step();
        chk0("err_sticky", 4'b0001, 2'd0, 1'b1, 1'b1);
        i0.REL = 4'b0001;
        step();
        i0.REL = '0;
        chk0("err_sticky_idle", 4'b0000, 2'd0, 1'b0, 1'b1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk0("err_clr", 4'b0000, 2'd0, 1'b0, 1'b0);

        // reset mid-grant, REQ kept high
        i0.REQ = 4'b0001;
        step(); step(); step();
        chk0("pre_rst", 4'b0001, 2'd0, 1'b1, 1'b0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk0("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        chk0("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);
        i0.REQ = '0; i0.REL = 4'b0001;
        step();
        i0.REL = '0;
        chk0("post_rst_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

        // REL while idle sets ERR
        i0.REL = 4'b0100;
        step();
        i0.REL = '0;
        chk0("idle_rel", 4'b0000, 2'd0, 1'b0, 1'b1);

        // watchdog HOLD_MAX=3: equal IDs so index 0 wins first
        i1.REQ = 4'b0011;
        i1.ID  = {8'd0, 8'd0, 8'd5, 8'd5};
        step();
        chk1("wd_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
        step();
        chk1("wd_c2", 4'b0001, 2'd0, 1'b1, 1'b0);
        step();
        chk1("wd_c3", 4'b0001, 2'd0, 1'b1, 1'b0);
        step();
        chk1("wd_revoke", 4'b0010, 2'd1, 1'b1, 1'b1);
        i1.REQ = '0; i1.REL = 4'b0010;
        step();
        i1.REL = '0;
        chk1("wd_idle", 4'b0000, 2'd0, 1'b0, 1'b1);
        RST = 1'b1;
        step();
        RST = 1'b0;

        // release on the timeout cycle is a clean release
        i1.REQ = 4'b0011;
        step();
        chk1("wdr_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
        step(); step();
        i1.REL = 4'b0001;
        step();
        i1.REL = '0;
        chk1("wdr_hand", 4'b0010, 2'd1, 1'b1, 1'b0);
        i1.REQ = '0; i1.REL = 4'b0010;
        step();
        i1.REL = '0;
        chk1("wdr_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
